// File: rtl/tdc_readout.sv
// rtl/tdc_readout.sv - thermometer TDC reader: fire, capture, validate, decode and average shots
module tdc_readout #(
    parameter int LOG2_AVG      = 3,
    parameter int CLR_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int TIMEOUT       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            term,
    input  logic                  start_req,
    input  logic                  abort,
    output logic                  tdc_clr,
    output logic                  tdc_trig,
    output logic                  busy,
    output logic                  done,
    output logic [4+LOG2_AVG-1:0] sum,
    output logic [3:0]            avg,
    output logic                  bubble_err,
    output logic                  unstable,
    output logic [7:0]            last_code
);

    localparam int         SW        = 4 + LOG2_AVG;
    localparam int         CW        = 16;
    localparam logic [6:0] LAST_SHOT = 7'((1 << LOG2_AVG) - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_TRIG, S_SETTLE, S_CAPTURE, S_ACCUM, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    shot_q, shot_d;
    logic [SW-1:0] acc_q, acc_d;
    logic          bub_flag_q, bub_flag_d;
    logic          unst_flag_q, unst_flag_d;
    logic [7:0]    last_code_q, last_code_d;
    logic [SW-1:0] sum_q, sum_d;
    logic [3:0]    avg_q, avg_d;
    logic          bubble_err_q, bubble_err_d;
    logic          unstable_q, unstable_d;
    logic          tdc_clr_q, tdc_clr_d;
    logic          tdc_trig_q, tdc_trig_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [3:0]    pop;
    logic          thermo_ok;

    // Decode the captured code: tap count and contiguous-ones check
    always_comb begin
        pop = '0;
        for (int i = 0; i < 8; i++) begin
            pop = pop + {3'b000, last_code_q[i]};
        end
        thermo_ok = ((last_code_q & (last_code_q + 8'd1)) == 8'd0);
    end

    // Next-state logic for the burst sequencer, synchroniser and result registers
    always_comb begin
        state_d      = state_q;
        s1_d         = term;
        s2_d         = s1_q;
        s3_d         = s2_q;
        cnt_d        = cnt_q;
        shot_d       = shot_q;
        acc_d        = acc_q;
        bub_flag_d   = bub_flag_q;
        unst_flag_d  = unst_flag_q;
        last_code_d  = last_code_q;
        sum_d        = sum_q;
        avg_d        = avg_q;
        bubble_err_d = bubble_err_q;
        unstable_d   = unstable_q;

        case (state_q)
            S_IDLE: begin
                if (start_req && !abort) begin
                    acc_d       = '0;
                    shot_d      = '0;
                    bub_flag_d  = 1'b0;
                    unst_flag_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (cnt_q == CW'(CLR_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_TRIG;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_TRIG: begin
                cnt_d   = '0;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_CAPTURE: begin
                if (s2_q == s3_q) begin
                    last_code_d = s2_q;
                    cnt_d       = '0;
                    state_d     = S_ACCUM;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // Code never settled: take it anyway and flag the burst
                    last_code_d = s2_q;
                    unst_flag_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_ACCUM;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_ACCUM: begin
                acc_d = acc_q + SW'(pop);
                if (!thermo_ok) begin
                    bub_flag_d = 1'b1;
                end
                if (shot_q == LAST_SHOT) begin
                    state_d = S_DONE;
                end else begin
                    shot_d  = shot_q + 7'd1;
                    state_d = S_CLEAR;
                end
            end
            S_DONE: begin
                sum_d        = acc_q;
                avg_d        = 4'(acc_q >> LOG2_AVG);
                bubble_err_d = bub_flag_q;
                unstable_d   = unst_flag_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort beats every transition and leaves published results untouched
        if (abort && state_q != S_IDLE) begin
            state_d      = S_IDLE;
            cnt_d        = '0;
            sum_d        = sum_q;
            avg_d        = avg_q;
            bubble_err_d = bubble_err_q;
            unstable_d   = unstable_q;
        end
    end

    // Registered outputs follow the state being entered so they line up with it
    always_comb begin
        tdc_clr_d  = (state_d == S_CLEAR);
        tdc_trig_d = (state_d == S_TRIG);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_q == S_DONE) && !abort;
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            s1_q         <= '0;
            s2_q         <= '0;
            s3_q         <= '0;
            cnt_q        <= '0;
            shot_q       <= '0;
            acc_q        <= '0;
            bub_flag_q   <= 1'b0;
            unst_flag_q  <= 1'b0;
            last_code_q  <= '0;
            sum_q        <= '0;
            avg_q        <= '0;
            bubble_err_q <= 1'b0;
            unstable_q   <= 1'b0;
            tdc_clr_q    <= 1'b0;
            tdc_trig_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            cnt_q        <= cnt_d;
            shot_q       <= shot_d;
            acc_q        <= acc_d;
            bub_flag_q   <= bub_flag_d;
            unst_flag_q  <= unst_flag_d;
            last_code_q  <= last_code_d;
            sum_q        <= sum_d;
            avg_q        <= avg_d;
            bubble_err_q <= bubble_err_d;
            unstable_q   <= unstable_d;
            tdc_clr_q    <= tdc_clr_d;
            tdc_trig_q   <= tdc_trig_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign tdc_clr    = tdc_clr_q;
    assign tdc_trig   = tdc_trig_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign sum        = sum_q;
    assign avg        = avg_q;
    assign bubble_err = bubble_err_q;
    assign unstable   = unstable_q;
    assign last_code  = last_code_q;

endmodule

// File: tb/tb_tdc_readout.sv
// tb/tb_tdc_readout.sv - directed self-checking bench for tdc_readout
module tb_tdc_readout;

    logic       clk;
    logic       rst;
    logic [7:0] term;
    logic       start_req;
    logic       abort;
    logic       tdc_clr, tdc_trig, busy, done, bubble_err, unstable;
    logic [6:0] sum;
    logic [3:0] avg;
    logic [7:0] last_code;

    logic       start_req0;
    logic       tdc_clr0, tdc_trig0, busy0, done0, bubble_err0, unstable0;
    logic [3:0] sum0;
    logic [3:0] avg0;
    logic [7:0] last_code0;

    int checks;
    int errors;

    tdc_readout u_dut (
        .clk(clk), .rst(rst), .term(term), .start_req(start_req), .abort(abort),
        .tdc_clr(tdc_clr), .tdc_trig(tdc_trig), .busy(busy), .done(done),
        .sum(sum), .avg(avg), .bubble_err(bubble_err), .unstable(unstable),
        .last_code(last_code)
    );

    tdc_readout #(.LOG2_AVG(0)) u_dut0 (
        .clk(clk), .rst(rst), .term(term), .start_req(start_req0), .abort(1'b0),
        .tdc_clr(tdc_clr0), .tdc_trig(tdc_trig0), .busy(busy0), .done(done0),
        .sum(sum0), .avg(avg0), .bubble_err(bubble_err0), .unstable(unstable0),
        .last_code(last_code0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Runs one burst on u_dut; cycle n counts edges after the accepting edge
    task automatic run_burst(input logic [7:0] t1, input bit toggle, input int sw_at,
                             input logic [7:0] t2, input int spur_at, input int abort_at,
                             input int budget, output int done_cyc, output int trigs,
                             output int clr_bad, output int ab_state);
        int n;
        int run;
        bit stop;
        bit switched;
        term = t1;
        start_req = 1'b0;
        abort = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start_req = 1'b1;
        @(posedge clk);
        #1;
        start_req = 1'b0;
        run = tdc_clr ? 1 : 0;
        n = 0; trigs = 0; done_cyc = 0; clr_bad = 0; ab_state = -1;
        stop = 1'b0; switched = 1'b0;
        while (!stop && n < budget) begin
            @(posedge clk);
            #1;
            n++;
            start_req = 1'b0;
            if (done) begin
                done_cyc = n;
                stop = 1'b1;
            end
            if (tdc_clr) run++;
            if (tdc_trig) begin
                if (run != 4) clr_bad++;
                run = 0;
                trigs++;
                if (trigs == spur_at) start_req = 1'b1;
                if (trigs == abort_at) begin
                    abort = 1'b1;
                    @(posedge clk);
                    #1;
                    abort = 1'b0;
                    ab_state = int'({busy, tdc_clr, tdc_trig});
                    stop = 1'b1;
                end
            end
            if (toggle) term = (term == 8'h03) ? 8'h07 : 8'h03;
            if (!switched && trigs == sw_at && tdc_clr) begin
                term = t2;
                switched = 1'b1;
            end
        end
    endtask

    initial begin
        int dc, tr, cb, ab, n, tr0, ndone;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        term = 8'h00;
        start_req = 1'b0;
        start_req0 = 1'b0;
        abort = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {busy, tdc_clr, tdc_trig, done, bubble_err, unstable, sum, avg, last_code}, 0);
        check("reset_outs0", {busy0, tdc_clr0, tdc_trig0, done0, sum0, avg0, last_code0}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Stable 0x0F
        run_burst(8'h0F, 1'b0, 99, 8'h00, -1, -1, 200, dc, tr, cb, ab);
        check("stable_done_cyc", dc, 121);
        check("stable_trigs", tr, 8);
        check("stable_clr_len", cb, 0);
        check("stable_sum", sum, 32);
        check("stable_avg", avg, 4);
        check("stable_bubble", bubble_err, 0);
        check("stable_unstable", unstable, 0);
        check("stable_last", last_code, 8'h0F);
        check("stable_idle", busy, 0);

        // Full scale then bubble code
        run_burst(8'hFF, 1'b0, 4, 8'h0B, -1, -1, 200, dc, tr, cb, ab);
        check("bub_done_cyc", dc, 121);
        check("bub_sum", sum, 44);
        check("bub_avg", avg, 5);
        check("bub_bubble", bubble_err, 1);
        check("bub_unstable", unstable, 0);
        check("bub_last", last_code, 8'h0B);

        // Abort during the third shot
        run_burst(8'h01, 1'b0, 99, 8'h00, -1, 3, 200, dc, tr, cb, ab);
        check("abort_state", ab, 0);
        check("abort_no_done", dc, 0);
        ndone = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        check("abort_quiet", ndone, 0);
        check("abort_sum_kept", sum, 44);
        check("abort_avg_kept", avg, 5);
        check("abort_flags_kept", {bubble_err, unstable}, 2'b10);

        // New burst with a spurious start_req mid-burst
        run_burst(8'h01, 1'b0, 99, 8'h00, 2, -1, 200, dc, tr, cb, ab);
        check("spur_done_cyc", dc, 121);
        check("spur_trigs", tr, 8);
        check("spur_sum", sum, 8);
        check("spur_avg", avg, 1);
        check("spur_flags", {bubble_err, unstable}, 2'b00);
        check("spur_last", last_code, 8'h01);

        // Term toggling every cycle: every capture times out
        run_burst(8'h03, 1'b1, 99, 8'h00, -1, -1, 400, dc, tr, cb, ab);
        check("meta_done_cyc", dc, 241);
        check("meta_unstable", unstable, 1);
        check("meta_bubble", bubble_err, 0);
        check("meta_sum_range", (sum >= 7'd16 && sum <= 7'd24), 1);
        check("meta_last", (last_code == 8'h03 || last_code == 8'h07), 1);

        // Single-shot instance
        term = 8'h7F;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start_req0 = 1'b1;
        @(posedge clk);
        #1;
        start_req0 = 1'b0;
        n = 0; tr0 = 0; dc = 0;
        while (dc == 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (tdc_trig0) tr0++;
            if (done0) dc = n;
        end
        check("one_done_cyc", dc, 16);
        check("one_trigs", tr0, 1);
        check("one_sum", sum0, 7);
        check("one_avg", avg0, 7);

        // start_req together with abort in IDLE
        @(negedge clk);
        start_req = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start_req = 1'b0;
        abort = 1'b0;
        check("idle_abort_wins", {busy, tdc_clr}, 2'b00);

        // Reset asserted mid-SETTLE
        term = 8'h0F;
        @(negedge clk);
        start_req = 1'b1;
        @(posedge clk);
        #1;
        start_req = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("pre_reset_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_outs", {busy, tdc_clr, tdc_trig, done, bubble_err, unstable, sum, avg, last_code}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
